watch_display_scan: RTL and testbench

Time-multiplexed 6-digit 7-segment display driver that consumes the watch digit bus (hr1, hr0, min1, min0, sec1, sec0; 4-bit BCD each) produced by the watch counter chain. It runs on the fast system clock, scans one digit per slot, and latches a coherent snapshot of all six digits at each frame start so ripple carries mid-frame never tear the display. It also provides per-digit blink for time setting, hour-tens leading-zero blanking, a colon via decimal points, and anti-ghost blanking.

---
 rtl/watch_display_scan.sv | 188 ++++++++++++++++++
 tb/tb_watch_display_scan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the watch digit bus.
// One digit is driven per slot. A coherent snapshot of all six digits is
// latched at each frame start, so counter ripple mid-frame never tears the
// display. Also handles blink, hour-tens zero blanking, colon dots and
// inter-digit anti-ghost blanking.
module watch_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int BLINK_HALF     = 100,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr1,
    input  logic [3:0] hr0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [5:0] blink_mask,
    input  logic       lz_blank,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_V    = PW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [6:0]    SEG_XOR    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic          DP_XOR     = (SEG_ACTIVE_LOW != 0);
    localparam logic [5:0]    AN_XOR     = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    // Scan and blink state
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    slot_q, slot_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Snapshot of the digit bus, indexed like an/blink_mask (5=hr1 .. 0=sec0)
    logic [3:0] digit_in [6];
    logic [3:0] shadow_q [6];

    // Registered (polarity-adjusted) outputs
    logic [6:0] seg_q;
    logic       dp_q;
    logic [5:0] an_q;
    logic       frame_done_q;

    // Decoded display values before registering
    logic [6:0] seg_d;
    logic       dp_d;
    logic [5:0] an_d;
    logic       frame_done_d;

    logic       tick;
    logic       frame_end;
    logic       snap;
    logic [2:0] digit_idx;
    logic [3:0] cur_digit;
    logic       enable;

    assign digit_in[5] = hr1;
    assign digit_in[4] = hr0;
    assign digit_in[3] = min1;
    assign digit_in[2] = min0;
    assign digit_in[1] = sec1;
    assign digit_in[0] = sec0;

    assign tick      = (presc_q == PRESC_LAST);
    assign frame_end = tick && (slot_q == 3'd5);
    assign snap      = (presc_q == '0) && (slot_q == 3'd0);
    assign digit_idx = 3'd5 - slot_q;

    // Next-state for prescaler, slot index and blink timing
    always_comb begin
        presc_d       = tick ? '0 : presc_q + 1'b1;
        slot_d        = slot_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Scan counters and blink phase
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            slot_q        <= 3'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // One snapshot register per digit, loaded at the first cycle of a frame
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q[gi] <= 4'd0;
                end else if (snap) begin
                    shadow_q[gi] <= digit_in[gi];
                end
            end
        end
    endgenerate

    // Select the digit for the current slot, gate it and decode to segments
    always_comb begin
        case (slot_q)
            3'd0:    cur_digit = shadow_q[5];
            3'd1:    cur_digit = shadow_q[4];
            3'd2:    cur_digit = shadow_q[3];
            3'd3:    cur_digit = shadow_q[2];
            3'd4:    cur_digit = shadow_q[1];
            3'd5:    cur_digit = shadow_q[0];
            default: cur_digit = 4'd0;
        endcase

        enable = (presc_q >= BLANK_V)
              && !(blink_phase_q && blink_mask[digit_idx])
              && !((slot_q == 3'd0) && lz_blank && (shadow_q[5] == 4'd0));

        case (cur_digit)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = 7'h40;
        endcase

        an_d = 6'b000001 << digit_idx;
        dp_d = colon_en && ((slot_q == 3'd1) || (slot_q == 3'd3));
        if (!enable) begin
            seg_d = 7'h00;
            an_d  = 6'h00;
            dp_d  = 1'b0;
        end
        frame_done_d = frame_end;
    end

    // Output registers with polarity applied
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q        <= SEG_XOR;
            dp_q         <= DP_XOR;
            an_q         <= AN_XOR;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d ^ SEG_XOR;
            dp_q         <= dp_d ^ DP_XOR;
            an_q         <= an_d ^ AN_XOR;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_watch_display_scan.sv
// Scoreboard bench for watch_display_scan (SCAN_DIV=8, BLANK_CYC=2,
// BLINK_HALF=2, all outputs active low). Stimulus pushes the hand-computed
// sequence of lit digits; a monitor pops one entry each time a digit turns on.
module tb_watch_display_scan;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BH = 2;
    localparam int LIT_LEN   = SD - BC;
    localparam int FRAME_LEN = 6 * SD;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hr1 = 4'd0, hr0 = 4'd0, min1 = 4'd0, min0 = 4'd0, sec1 = 4'd0, sec0 = 4'd0;
    logic [5:0] blink_mask = 6'd0;
    logic       lz_blank = 1'b0;
    logic       colon_en = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    int   cyc = 0;

    watch_display_scan #(
        .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_HALF(BH),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset),
        .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .colon_en(colon_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: frame_done spacing, digit-on events against the queue, lit run length
    int         last_fd = 0;
    logic [5:0] prev_an = 6'h3F;
    int         run_len = 0;
    bit         run_chk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_fd = 0;
        end else if (frame_done === 1'b1) begin
            n_cmp++;
            if (cyc - last_fd != FRAME_LEN) begin
                n_err++;
                $display("FAIL frame_period: got %0d cycles, need %0d", cyc - last_fd, FRAME_LEN);
            end
            last_fd = cyc;
        end
        if (an !== 6'h3F && !$isunknown(an)) begin
            if (an !== prev_an) begin
                if (prev_an !== 6'h3F && run_chk) begin
                    n_cmp++;
                    if (run_len != LIT_LEN) begin
                        n_err++;
                        $display("FAIL lit_len: got %0d, need %0d", run_len, LIT_LEN);
                    end
                end
                run_len = 1;
                run_chk = chk_en;
                if (chk_en) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL digit_on: unexpected an=%b seg=%b dp=%b", an, seg, dp);
                    end else begin
                        e = exp_q.pop_front();
                        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                            n_err++;
                            $display("FAIL digit_on: got an=%b seg=%b dp=%b, need an=%b seg=%b dp=%b",
                                     an, seg, dp, e.an, e.seg, e.dp);
                        end else begin
                            $display("digit an=%b seg=%b dp=%b ok", an, seg, dp);
                        end
                    end
                end
            end else begin
                run_len++;
            end
        end else if (prev_an !== 6'h3F && run_chk) begin
            n_cmp++;
            if (run_len != LIT_LEN) begin
                n_err++;
                $display("FAIL lit_len: got %0d, need %0d", run_len, LIT_LEN);
            end
            run_chk = 1'b0;
        end
        prev_an = an;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        n_cmp++;
        if (got !== need) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, got, need);
        end
    endtask

    // Assert reset (called at a negedge), check outputs one cycle later, release
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_an", 32'(an), 32'h3F);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        $display("reset an=%b seg=%b dp=%b fd=%b", an, seg, dp, frame_done);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hr1 = a; hr0 = b; min1 = c; min0 = d; sec1 = e; sec0 = f;
    endtask

    // Push one frame; codes are active-high per slot, vis bit5=hr1 .. bit0=sec0
    task automatic push_frame(input logic [6:0] c0, c1, c2, c3, c4, c5,
                              input logic [5:0] vis, input bit colon);
        logic [6:0] codes [6];
        logic [5:0] one;
        exp_t       e;
        codes[0] = c0; codes[1] = c1; codes[2] = c2;
        codes[3] = c3; codes[4] = c4; codes[5] = c5;
        for (int s = 0; s < 6; s++) begin
            if (vis[5-s]) begin
                one   = 6'b000001;
                e.an  = ~(one << (5 - s));
                e.seg = ~codes[s];
                e.dp  = ~(colon && (s == 1 || s == 3));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME_LEN && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_frame: got no frame_done, need one");
        end
    endtask

    task automatic wait_an(input logic [5:0] target);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME_LEN && !seen; i++) begin
            @(negedge clk);
            if (an === target) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_an: got no an=%b, need it", target);
        end
    endtask

    // Let the last lit run finish, then confirm every expectation was consumed
    task automatic end_segment(input string name);
        repeat (2) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk_en = 1'b0;
    endtask

    initial begin
        // 12:34:56 with min0 changed mid-frame
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        @(negedge clk);
        do_reset();
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 6'h3F, 1'b0);
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h07, 7'h6D, 7'h7D, 6'h3F, 1'b0);
        chk_en = 1'b1;
        wait_an(6'b110111);
        min0 = 4'd7;
        wait_frame();
        wait_frame();
        end_segment("left_static");

        // 01:00:00, leading-zero blank then disabled live
        set_time(4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        lz_blank = 1'b1;
        do_reset();
        push_frame(7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 6'b011111, 1'b0);
        push_frame(7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 6'b111111, 1'b0);
        chk_en = 1'b1;
        wait_frame();
        lz_blank = 1'b0;
        wait_frame();
        end_segment("left_lz");

        // Seconds blink: lit 0-1, dark 2-3, lit 4-5
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blink_mask = 6'b000011;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                       (f == 2 || f == 3) ? 6'b111100 : 6'b111111, 1'b0);
        end
        chk_en = 1'b1;
        repeat (6) wait_frame();
        end_segment("left_blink");
        blink_mask = 6'b000000;

        // Invalid sec0 shows dash, colon dots, then reset during slot 4
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC);
        colon_en = 1'b1;
        do_reset();
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h40, 6'h3F, 1'b1);
        chk_en = 1'b1;
        wait_frame();
        end_segment("left_dash");
        wait_an(6'b111101);
        do_reset();
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h40, 6'h3F, 1'b1);
        chk_en = 1'b1;
        wait_frame();
        end_segment("left_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

endmodule
